// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//
// Pipelined MIPS decode stage. Fetched {instruction, pc} pairs are buffered in
// a DEPTH-entry circular queue. The queue head is decoded combinationally and
// moved into a registered output slot under a valid/ready handshake toward
// execute. A flush empties the queue and the slot in a single edge.
//
// Optional feature macro: DECODE_HAZARD_EN
//   When defined, a load-use interlock is compiled in. A 32-bit pending-load
//   scoreboard holds back the head while one of its sources is still waiting
//   on a load result.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     fetch handshake; in_inst, in_pc are the payload
//   flush                 kill everything held in the stage
//   wb_valid, wb_addr     load write-back notification (interlock build only)
//   out_valid/out_ready   execute handshake for the decoded slot
//   out_pc                pc of the slotted instruction
//   wa, ra1, ra2          register write / read addresses
//   reg_wen               register write enable
//   imm_ext, imm, addr    immediate extension mode, immediate, jump field
//   alu_op                ALU function code (R-type funct encoding)
//   pc_src, mem_cmd,
//   alu_src, reg_src      mux and memory controls
//   illegal               slot holds an unsupported opcode or funct
// ---------------------------------------------------------------------------
`ifndef DECODE_STAGE_DEFS
`define DECODE_STAGE_DEFS
`define W_CPU        32
`define W_REG        5
`define W_IMM        16
`define W_JADDR      26
`define W_FUNCT      6
`define W_IMM_EXT    1
`define W_PC_SRC     2
`define W_MEM_CMD    2
`define W_ALU_SRC    1
`define W_REG_SRC    2
`define IMM_ZERO_EXT 1'b0
`define IMM_SIGN_EXT 1'b1
`define WEN          1'b1
`define WDIS         1'b0
`define PC_SRC_NEXT   2'd0
`define PC_SRC_JUMP   2'd1
`define PC_SRC_BRANCH 2'd2
`define PC_SRC_REG    2'd3
`define MEM_NOP      2'd0
`define MEM_READ     2'd1
`define MEM_WRITE    2'd2
`define ALU_SRC_REG  1'b0
`define ALU_SRC_IMM  1'b1
`define REG_SRC_ALU  2'd0
`define REG_SRC_MEM  2'd1
`define REG_SRC_PC   2'd2
`endif

module decode_stage #(
    parameter int DEPTH = 4,
    parameter int W_PC  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [`W_CPU-1:0]      in_inst,
    input  logic [W_PC-1:0]        in_pc,
    input  logic                   flush,
    input  logic                   wb_valid,
    input  logic [`W_REG-1:0]      wb_addr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W_PC-1:0]        out_pc,
    output logic [`W_REG-1:0]      wa,
    output logic [`W_REG-1:0]      ra1,
    output logic [`W_REG-1:0]      ra2,
    output logic                   reg_wen,
    output logic [`W_IMM_EXT-1:0]  imm_ext,
    output logic [`W_IMM-1:0]      imm,
    output logic [`W_JADDR-1:0]    addr,
    output logic [`W_FUNCT-1:0]    alu_op,
    output logic [`W_PC_SRC-1:0]   pc_src,
    output logic [`W_MEM_CMD-1:0]  mem_cmd,
    output logic [`W_ALU_SRC-1:0]  alu_src,
    output logic [`W_REG_SRC-1:0]  reg_src,
    output logic                   illegal
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_BLEZ  = 6'h06;
    localparam logic [5:0] OP_BGTZ  = 6'h07, OP_ADDI = 6'h08, OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A, OP_SLTIU= 6'h0B, OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D, OP_XORI = 6'h0E, OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20, OP_LH   = 6'h21, OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24, OP_LHU  = 6'h25, OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29, OP_SW   = 6'h2B;

    // R-type funct codes (also the ALU operation encoding)
    localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04, F_SRLV = 6'h06, F_SRAV = 6'h07;
    localparam logic [5:0] F_JR   = 6'h08, F_JALR = 6'h09, F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21, F_SUB  = 6'h22, F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24, F_OR   = 6'h25, F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27, F_SLT  = 6'h2A, F_SLTU = 6'h2B;

    logic [`W_CPU-1:0] mem_inst_r [DEPTH];
    logic [W_PC-1:0]   mem_pc_r   [DEPTH];
    logic [AW:0]       wr_ptr_r;
    logic [AW:0]       rd_ptr_r;

    logic              empty_s;
    logic              full_s;
    logic              push_s;
    logic              pop_s;
    logic              stall_s;

    logic [`W_CPU-1:0] head_inst_s;
    logic [W_PC-1:0]   head_pc_s;
    logic [5:0]        opcode_s;
    logic [5:0]        funct_s;
    logic [4:0]        rs_s;
    logic [4:0]        rt_s;
    logic [4:0]        rd_s;

    logic [`W_REG-1:0]     dec_wa_s;
    logic                  dec_reg_wen_s;
    logic [`W_IMM_EXT-1:0] dec_imm_ext_s;
    logic [`W_FUNCT-1:0]   dec_alu_op_s;
    logic [`W_PC_SRC-1:0]  dec_pc_src_s;
    logic [`W_MEM_CMD-1:0] dec_mem_cmd_s;
    logic [`W_ALU_SRC-1:0] dec_alu_src_s;
    logic [`W_REG_SRC-1:0] dec_reg_src_s;
    logic                  dec_illegal_s;

    // MSB of the pointers separates the full and empty cases when the indices match
    assign empty_s  = (wr_ptr_r == rd_ptr_r);
    assign full_s   = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                      (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign in_ready = !full_s;
    assign push_s   = in_valid && !full_s && !flush;
    assign pop_s    = !empty_s && !stall_s && (!out_valid || out_ready) && !flush;

    assign head_inst_s = mem_inst_r[rd_ptr_r[AW-1:0]];
    assign head_pc_s   = mem_pc_r[rd_ptr_r[AW-1:0]];
    assign opcode_s    = head_inst_s[31:26];
    assign rs_s        = head_inst_s[25:21];
    assign rt_s        = head_inst_s[20:16];
    assign rd_s        = head_inst_s[15:11];
    assign funct_s     = head_inst_s[5:0];

    // Queue storage; the payload needs no reset since the pointers gate it
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_inst_r[wr_ptr_r[AW-1:0]] <= in_inst;
            mem_pc_r[wr_ptr_r[AW-1:0]]   <= in_pc;
        end
    end

    // Queue pointers; flush empties the queue ahead of any push or pop
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Combinational decode of the queue head into control fields
    always_comb begin
        dec_wa_s      = 5'd0;
        dec_reg_wen_s = `WDIS;
        dec_imm_ext_s = `IMM_ZERO_EXT;
        dec_alu_op_s  = 6'd0;
        dec_pc_src_s  = `PC_SRC_NEXT;
        dec_mem_cmd_s = `MEM_NOP;
        dec_alu_src_s = `ALU_SRC_REG;
        dec_reg_src_s = `REG_SRC_ALU;
        dec_illegal_s = 1'b0;
        case (opcode_s)
            OP_RTYPE: begin
                case (funct_s)
                    F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV,
                    F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR,
                    F_XOR, F_NOR, F_SLT, F_SLTU: begin
                        dec_wa_s      = rd_s;
                        dec_alu_op_s  = funct_s;
                        dec_reg_wen_s = `WEN;
                    end
                    F_JR: begin
                        dec_wa_s      = rd_s;
                        dec_alu_op_s  = funct_s;
                        dec_pc_src_s  = `PC_SRC_REG;
                    end
                    F_JALR: begin
                        dec_wa_s      = rd_s;
                        dec_alu_op_s  = funct_s;
                        dec_reg_wen_s = `WEN;
                        dec_pc_src_s  = `PC_SRC_REG;
                        dec_reg_src_s = `REG_SRC_PC;
                    end
                    default: begin
                        dec_illegal_s = 1'b1;
                    end
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                dec_wa_s      = rt_s;
                dec_alu_src_s = `ALU_SRC_IMM;
                dec_reg_wen_s = `WEN;
                // immediate forms reuse the matching R-type ALU operation
                case (opcode_s)
                    OP_ADDI:  begin dec_alu_op_s = F_ADD;  dec_imm_ext_s = `IMM_SIGN_EXT; end
                    OP_ADDIU: begin dec_alu_op_s = F_ADDU; dec_imm_ext_s = `IMM_SIGN_EXT; end
                    OP_SLTI:  begin dec_alu_op_s = F_SLT;  dec_imm_ext_s = `IMM_SIGN_EXT; end
                    OP_SLTIU: begin dec_alu_op_s = F_SLTU; dec_imm_ext_s = `IMM_SIGN_EXT; end
                    OP_ANDI:  begin dec_alu_op_s = F_AND;  dec_imm_ext_s = `IMM_ZERO_EXT; end
                    OP_ORI:   begin dec_alu_op_s = F_OR;   dec_imm_ext_s = `IMM_ZERO_EXT; end
                    OP_XORI:  begin dec_alu_op_s = F_XOR;  dec_imm_ext_s = `IMM_ZERO_EXT; end
                    default:  begin dec_alu_op_s = F_SLL;  dec_imm_ext_s = `IMM_ZERO_EXT; end
                endcase
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                dec_wa_s      = rt_s;
                dec_alu_op_s  = F_ADD;
                dec_imm_ext_s = `IMM_SIGN_EXT;
                dec_alu_src_s = `ALU_SRC_IMM;
                dec_mem_cmd_s = `MEM_READ;
                dec_reg_src_s = `REG_SRC_MEM;
                dec_reg_wen_s = `WEN;
            end
            OP_SB, OP_SH, OP_SW: begin
                dec_alu_op_s  = F_ADD;
                dec_imm_ext_s = `IMM_SIGN_EXT;
                dec_alu_src_s = `ALU_SRC_IMM;
                dec_mem_cmd_s = `MEM_WRITE;
            end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
                dec_alu_op_s  = F_SUB;
                dec_imm_ext_s = `IMM_SIGN_EXT;
                dec_pc_src_s  = `PC_SRC_BRANCH;
            end
            OP_J: begin
                dec_pc_src_s  = `PC_SRC_JUMP;
            end
            OP_JAL: begin
                dec_pc_src_s  = `PC_SRC_JUMP;
                dec_wa_s      = 5'd31;
                dec_reg_src_s = `REG_SRC_PC;
                dec_reg_wen_s = `WEN;
            end
            default: begin
                dec_illegal_s = 1'b1;
            end
        endcase
    end

`ifdef DECODE_HAZARD_EN
    logic [31:0] pend_r;
    logic [31:0] pend_set_s;
    logic [31:0] pend_clr_s;
    logic [31:0] pend_eff_s;
    logic        uses_rt_s;
    logic        slot_load_s;
    logic        rs_hit_s;
    logic        rt_hit_s;

    assign slot_load_s = out_valid && (mem_cmd == `MEM_READ) && (wa != 5'd0);
    assign uses_rt_s   = (opcode_s == OP_RTYPE) || (opcode_s == OP_SB) ||
                         (opcode_s == OP_SH) || (opcode_s == OP_SW) ||
                         (opcode_s == OP_BEQ) || (opcode_s == OP_BNE);

    // Scoreboard set/clear masks and the stall decision for the queue head
    always_comb begin
        pend_set_s = 32'd0;
        pend_clr_s = 32'd0;
        if (slot_load_s && out_ready) begin
            pend_set_s[wa] = 1'b1;
        end else begin
            pend_set_s = 32'd0;
        end
        if (wb_valid) begin
            pend_clr_s[wb_addr] = 1'b1;
        end else begin
            pend_clr_s = 32'd0;
        end
        // a write-back this cycle already releases its register for the head
        pend_eff_s = pend_r & ~pend_clr_s;
        rs_hit_s   = pend_eff_s[rs_s] || (slot_load_s && (wa == rs_s));
        rt_hit_s   = uses_rt_s &&
                     (pend_eff_s[rt_s] || (slot_load_s && (wa == rt_s)));
        stall_s    = rs_hit_s || rt_hit_s;
    end

    // Pending-load scoreboard; set wins over a same-cycle clear, flush keeps it
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_r <= 32'd0;
        end else begin
            pend_r <= (pend_r & ~pend_clr_s) | pend_set_s;
        end
    end
`else
    logic unused_hazard_s;

    assign stall_s         = 1'b0;
    assign unused_hazard_s = ^{wb_valid, wb_addr};
`endif

    // Registered output slot; reset and flush clear every field
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            out_valid <= 1'b0;
            out_pc    <= {W_PC{1'b0}};
            wa        <= 5'd0;
            ra1       <= 5'd0;
            ra2       <= 5'd0;
            reg_wen   <= 1'b0;
            imm_ext   <= 1'b0;
            imm       <= 16'd0;
            addr      <= 26'd0;
            alu_op    <= 6'd0;
            pc_src    <= 2'd0;
            mem_cmd   <= 2'd0;
            alu_src   <= 1'b0;
            reg_src   <= 2'd0;
            illegal   <= 1'b0;
        end else if (pop_s) begin
            out_valid <= 1'b1;
            out_pc    <= head_pc_s;
            wa        <= dec_wa_s;
            ra1       <= rs_s;
            ra2       <= rt_s;
            reg_wen   <= dec_reg_wen_s;
            imm_ext   <= dec_imm_ext_s;
            imm       <= head_inst_s[15:0];
            addr      <= head_inst_s[25:0];
            alu_op    <= dec_alu_op_s;
            pc_src    <= dec_pc_src_s;
            mem_cmd   <= dec_mem_cmd_s;
            alu_src   <= dec_alu_src_s;
            reg_src   <= dec_reg_src_s;
            illegal   <= dec_illegal_s;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        flush;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [4:0]  wa;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic        reg_wen;
    logic [0:0]  imm_ext;
    logic [15:0] imm;
    logic [25:0] addr;
    logic [5:0]  alu_op;
    logic [1:0]  pc_src;
    logic [1:0]  mem_cmd;
    logic [0:0]  alu_src;
    logic [1:0]  reg_src;
    logic        illegal;

    int passed;
    int total;

    decode_stage #(.DEPTH(4), .W_PC(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .flush(flush), .wb_valid(wb_valid), .wb_addr(wb_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .wa(wa), .ra1(ra1), .ra2(ra2), .reg_wen(reg_wen),
        .imm_ext(imm_ext), .imm(imm), .addr(addr), .alu_op(alu_op),
        .pc_src(pc_src), .mem_cmd(mem_cmd), .alu_src(alu_src), .reg_src(reg_src),
        .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // backpressure table: ori, lw, sw, beq, add
    logic [31:0] bp_inst [5];
    logic [5:0]  bp_op   [5];
    logic [4:0]  bp_wa   [5];
    logic [1:0]  bp_mem  [5];

    initial begin
        passed = 0;
        total  = 0;
        bp_inst[0] = 32'h3549FFFF; bp_op[0] = 6'h25; bp_wa[0] = 5'd9;  bp_mem[0] = 2'd0;
        bp_inst[1] = 32'h8E080004; bp_op[1] = 6'h20; bp_wa[1] = 5'd8;  bp_mem[1] = 2'd1;
        bp_inst[2] = 32'hAFA90008; bp_op[2] = 6'h20; bp_wa[2] = 5'd0;  bp_mem[2] = 2'd2;
        bp_inst[3] = 32'h112A0003; bp_op[3] = 6'h22; bp_wa[3] = 5'd0;  bp_mem[3] = 2'd0;
        bp_inst[4] = 32'h012B5020; bp_op[4] = 6'h20; bp_wa[4] = 5'd10; bp_mem[4] = 2'd0;

        rst = 1'b1; in_valid = 1'b0; in_inst = 32'd0; in_pc = 32'd0;
        flush = 1'b0; wb_valid = 1'b0; wb_addr = 5'd0; out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;

        // reset state
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_wa", wa, 0);
        chk("rst_pc_src", pc_src, 0);

        // addi $t0,$zero,5 : latency and decoded fields
        in_valid = 1'b1; in_inst = 32'h20080005; in_pc = 32'h100;
        step();
        in_valid = 1'b0;
        chk("addi_latency", out_valid, 0);
        step();
        chk("addi_valid", out_valid, 1);
        chk("addi_wa", wa, 8);
        chk("addi_ra1", ra1, 0);
        chk("addi_imm", imm, 5);
        chk("addi_alu_op", alu_op, 6'h20);
        chk("addi_alu_src", alu_src, 1);
        chk("addi_reg_wen", reg_wen, 1);
        chk("addi_imm_ext", imm_ext, 1);
        chk("addi_pc", out_pc, 32'h100);
        step();
        chk("addi_consumed", out_valid, 0);

        // backpressure: slot plus DEPTH entries fill, sixth offer refused
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_inst  = (i < 5) ? bp_inst[i] : 32'h20080005;
            in_pc    = 32'h200 + 32'(4 * i);
            chk($sformatf("bp_in_ready_%0d", i), in_ready, (i < 5) ? 1 : 0);
            step();
        end
        in_valid = 1'b0;
        chk("bp_slot_valid", out_valid, 1);
        chk("bp_slot_pc", out_pc, 32'h200);
        chk("bp_slot_imm", imm, 16'hFFFF);
        chk("bp_slot_ext", imm_ext, 0);
        step();
        chk("bp_slot_stable", out_pc, 32'h200);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("drain_valid_%0d", i), out_valid, 1);
            chk($sformatf("drain_pc_%0d", i), out_pc, 32'h200 + 32'(4 * i));
            chk($sformatf("drain_alu_op_%0d", i), alu_op, bp_op[i]);
            chk($sformatf("drain_wa_%0d", i), wa, bp_wa[i]);
            chk($sformatf("drain_mem_%0d", i), mem_cmd, bp_mem[i]);
            step();
        end
        chk("drain_empty", out_valid, 0);

        // j 0x100 then jal 0x100
        in_valid = 1'b1; in_inst = 32'h08000100; in_pc = 32'h300;
        step();
        in_inst = 32'h0C000100; in_pc = 32'h304;
        step();
        in_valid = 1'b0;
        chk("j_pc_src", pc_src, 1);
        chk("j_addr", addr, 26'h100);
        chk("j_reg_wen", reg_wen, 0);
        step();
        chk("jal_pc_src", pc_src, 1);
        chk("jal_addr", addr, 26'h100);
        chk("jal_wa", wa, 31);
        chk("jal_reg_src", reg_src, 2);
        chk("jal_reg_wen", reg_wen, 1);
        step();

        // unsupported opcode 0x3F and undefined R-type funct 0x01
        in_valid = 1'b1; in_inst = 32'hFC000000; in_pc = 32'h340;
        step();
        in_inst = 32'h012B5001; in_pc = 32'h344;
        step();
        in_valid = 1'b0;
        chk("ill_op_valid", out_valid, 1);
        chk("ill_op_flag", illegal, 1);
        chk("ill_op_reg_wen", reg_wen, 0);
        chk("ill_op_mem", mem_cmd, 0);
        step();
        chk("ill_fn_flag", illegal, 1);
        chk("ill_fn_reg_wen", reg_wen, 0);
        step();

        // flush with slot full, three queued and an input offered
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_inst = 32'h3549FFFF; in_pc = 32'h500 + 32'(4 * i);
            step();
        end
        chk("pre_flush_valid", out_valid, 1);
        in_inst = 32'h3549FFFF; in_pc = 32'h510; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        chk("flush_pc_cleared", out_pc, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("flush_empty_%0d", i), out_valid, 0);
        end

`ifdef DECODE_HAZARD_EN
        // lw $t0,0($s0) followed by add $t1,$t0,$t0
        in_valid = 1'b1; in_inst = 32'h8E080000; in_pc = 32'h400;
        step();
        in_inst = 32'h01084820; in_pc = 32'h404;
        step();
        in_valid = 1'b0;
        chk("hz_lw_slot", out_pc, 32'h400);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("hz_stalled_%0d", i), out_valid, 0);
        end
        wb_valid = 1'b1; wb_addr = 5'd8;
        step();
        wb_valid = 1'b0;
        chk("hz_add_valid", out_valid, 1);
        chk("hz_add_pc", out_pc, 32'h404);
        chk("hz_add_wa", wa, 9);
        step();
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
